varredura_matriz_leds: RTL

VARREDURA_MATRIZ_LEDS -- requirements
Module: varredura_matriz_leds

---
 rtl/matriz_leds_pkg.sv | 44 ++++
 rtl/divisor_varredura.sv | 30 +++
 rtl/varredura_matriz_leds.sv | 117 +++++++++++
 3 files changed

// File: rtl/matriz_leds_pkg.sv
// matriz_leds_pkg
// Shared definitions for the LED matrix scanner:
//   - MODO_PRIORIDADE / MODO_TODOS : values of the Modo input
//   - prioridade_t                 : result of the priority encoder (valid + index)
//   - codifica_prioridade()        : channel vector -> highest-priority channel
// Priority order is column-major: lower column first, then lower row.
package matriz_leds_pkg;

    localparam logic MODO_PRIORIDADE = 1'b0;
    localparam logic MODO_TODOS      = 1'b1;

    // The encoder works on a fixed-width vector so it can live in the package;
    // callers zero-extend their channel vector (N_CH must not exceed MAX_CH).
    localparam int MAX_CH    = 256;
    localparam int MAX_IDX_W = 8;

    typedef struct packed {
        logic                 valido;
        logic [MAX_IDX_W-1:0] indice;
    } prioridade_t;

    // Channel k sits at row k / n_colunas, column k % n_colunas.
    // Scanning columns in the outer loop gives the column-major priority.
    function automatic prioridade_t codifica_prioridade(
        input logic [MAX_CH-1:0] ch,
        input int                n_linhas,
        input int                n_colunas
    );
        prioridade_t          res;
        logic [MAX_IDX_W-1:0] k;
        res = '0;
        for (int c = 0; c < n_colunas; c++) begin
            for (int r = 0; r < n_linhas; r++) begin
                k = MAX_IDX_W'(r * n_colunas + c);
                if (!res.valido && ch[k]) begin
                    res.valido = 1'b1;
                    res.indice = k;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/divisor_varredura.sv
// divisor_varredura
// Column-slot prescaler: counts 0..DIV-1 while enabled and wraps to 0.
//   clk   : clock
//   rst   : asynchronous active-high reset (count -> 0)
//   en    : count enable; count holds when low
//   count : current prescaler value
//   wrap  : high in the cycle where count = DIV-1 and en = 1, i.e. the
//           next rising edge returns count to 0
module divisor_varredura #(
    parameter int DIV = 4,
    parameter int W   = $clog2(DIV)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap
);

    assign wrap = en && (count == W'(DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/varredura_matriz_leds.sv
// varredura_matriz_leds
// Multiplexed LED matrix scanner. A frame is N_COLUNAS slots of
// DIV_VARREDURA cycles each; at every frame boundary the channel requests
// are captured (masked to the single highest-priority channel in priority
// mode) and shown column by column during the following frame.
//   Clock     : clock
//   Reset     : asynchronous active-high reset
//   CH        : channel requests, channel k = row k/N_COLUNAS, col k%N_COLUNAS
//   Habilita  : scan enable; all scan state freezes while low
//   Modo      : 0 = only highest-priority channel lit, 1 = all requested lit
//   Linha     : row drive for the current column (blank on the slot's first cycle)
//   Coluna    : one-hot column select
//   Indice    : highest-priority requested channel of the current frame
//   Valido    : the current frame had at least one request
//   FimQuadro : one-cycle pulse right after each frame boundary
module varredura_matriz_leds
    import matriz_leds_pkg::*;
#(
    parameter  int N_LINHAS      = 4,
    parameter  int N_COLUNAS     = 2,
    parameter  int DIV_VARREDURA = 4,
    localparam int N_CH          = N_LINHAS * N_COLUNAS,
    localparam int W_IDX         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [N_CH-1:0]      CH,
    input  logic                 Habilita,
    input  logic                 Modo,
    output logic [N_LINHAS-1:0]  Linha,
    output logic [N_COLUNAS-1:0] Coluna,
    output logic [W_IDX-1:0]     Indice,
    output logic                 Valido,
    output logic                 FimQuadro
);

    localparam int W_COL = (N_COLUNAS > 1) ? $clog2(N_COLUNAS) : 1;
    localparam int W_PRE = $clog2(DIV_VARREDURA);

    logic [W_PRE-1:0] pre;
    logic             pre_wrap;
    logic [W_COL-1:0] col_reg;
    logic [N_CH-1:0]  quadro_reg;
    logic [W_IDX-1:0] indice_reg;
    logic             valido_reg;
    logic             fim_reg;
    logic             col_ultima;
    logic             fronteira;
    prioridade_t      prio;
    logic [N_CH-1:0]  quadro_next;

    divisor_varredura #(
        .DIV (DIV_VARREDURA)
    ) u_divisor (
        .clk   (Clock),
        .rst   (Reset),
        .en    (Habilita),
        .count (pre),
        .wrap  (pre_wrap)
    );

    assign col_ultima = (col_reg == W_COL'(N_COLUNAS - 1));
    // pre_wrap already includes Habilita, so a disabled scan never hits a boundary.
    assign fronteira  = pre_wrap && col_ultima;

    assign prio = codifica_prioridade(MAX_CH'(CH), N_LINHAS, N_COLUNAS);

    // Upper encoder bits are always zero for a matrix of this size.
    logic prio_unused;
    assign prio_unused = ^prio.indice[MAX_IDX_W-1:W_IDX];

    always_comb begin
        quadro_next = '0;
        if (Modo == MODO_TODOS) begin
            quadro_next = CH;
        end else if (prio.valido) begin
            quadro_next = N_CH'(1) << prio.indice[W_IDX-1:0];
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            col_reg    <= '0;
            quadro_reg <= '0;
            indice_reg <= '0;
            valido_reg <= 1'b0;
            fim_reg    <= 1'b0;
        end else begin
            fim_reg <= fronteira;
            if (pre_wrap) begin
                col_reg <= col_ultima ? '0 : col_reg + 1'b1;
            end
            if (fronteira) begin
                quadro_reg <= quadro_next;
                indice_reg <= prio.indice[W_IDX-1:0];
                valido_reg <= prio.valido;
            end
        end
    end

    // Row drive: regroup the frame per row so each row bit is picked by column.
    generate
        for (genvar gi = 0; gi < N_LINHAS; gi++) begin : g_linha
            logic [N_COLUNAS-1:0] linha_bits;
            assign linha_bits = quadro_reg[gi*N_COLUNAS +: N_COLUNAS];
            // The first cycle of each slot is blanked so the previous column's
            // pattern never ghosts into the newly selected column.
            assign Linha[gi] = (Habilita && (pre != '0)) ? linha_bits[col_reg] : 1'b0;
        end
    endgenerate

    assign Coluna    = Habilita ? (N_COLUNAS'(1) << col_reg) : '0;
    assign Indice    = indice_reg;
    assign Valido    = valido_reg;
    assign FimQuadro = fim_reg;

endmodule
